page_table_writer: RTL and testbench
====================================

// Module: page_table_writer
// PURPOSE
//  Sequential writer for the process page table RAM read by the RAM MMU. Kernel/exec unit
//  issues commands to install one entry, map a run of pages onto consecutive frames, or
//  clear a process's table. Entries are written one per cycle at pt_addr = ptb + page
//  (9-bit wrap, the same arithmetic the MMU uses on lookup).
//  Entry format: [15]=assigned, [14]=read-only, [6:0]=frame, other bits passed through.
// PARAMETERS
//  PAGES     32  pages per process table (page index 5 bits)
//  PTA_W     9   page table RAM address width
//  ENTRY_W   16  page table entry width
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   synchronous reset, active low
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   block idle; command accepted when cmd_valid & cmd_ready
//  cmd_op     in   2   00 WRITE one, 01 MAP run, 10 CLEAR table, 11 reserved
//  cmd_ptb    in   12  page table base of target process
//  cmd_page   in   5   first page index (WRITE/MAP)
//  cmd_count  in   6   number of pages (MAP), 0..32
//  cmd_entry  in   16  entry (WRITE), first entry (MAP)
//  pt_we      out  1   page table RAM write enable
//  pt_addr    out  9   page table RAM address
//  pt_wdata   out  16  page table RAM write data
//  pt_rdata   in   16  RAM read data, 1-cycle latency (used only with PT_WRITER_VERIFY_EN)
//  done       out  1   1-cycle pulse: command finished
//  err        out  1   1-cycle pulse with done: command rejected or verify failed
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, pt_we=0, pt_addr=0, pt_wdata=0, done=0, err=0.
//  States: IDLE -> WRITE -> FIN -> IDLE (VERIFY inserted when macro enabled).
//  IDLE: cmd_ready=1. On accept at edge N, latch ptb/page/count/entry, go WRITE
//   (cmd_ready=0 from N+1 until return to IDLE).
//  WRITE: pt_we=1 each cycle, one entry per cycle, first write in cycle N+1.
//   WRITE op: 1 write, pt_wdata=cmd_entry.
//   MAP op: count writes; write k (0-based) at page+k, data = entry with [6:0]=entry[6:0]+k
//     (7-bit wrap), bits [15:7] unchanged.
//   CLEAR op: 32 writes, pages 0..31, data 16'h0000.
//   pt_addr = (ptb + page_idx) truncated to 9 bits; wrap past 511 to 0 is legal.
//  FIN: done=1 for exactly one cycle after last write cycle; then IDLE, cmd_ready=1.
//  Rejections (no RAM writes; FIN next cycle with done=1, err=1):
//   op=11; MAP with page+count > 32.
//  MAP with count=0: no writes, done=1 err=0 in cycle N+1.
//  cmd_valid while busy: ignored (not latched); master must hold until cmd_ready.
//  Reset mid-command: IDLE at next edge, pt_we=0; already-written entries stay.
// CONFIGURATION
//  PT_WRITER_VERIFY_EN defined: after each write cycle, one VERIFY cycle drives pt_we=0 and
//   the same pt_addr; pt_rdata sampled next cycle compared to pt_wdata. Mismatch aborts
//   remaining writes, FIN with done=1 err=1. Throughput 1 entry / 2 cycles.
//  Undefined: no VERIFY state, pt_rdata ignored, 1 entry / cycle.
// TESTING
//  WRITE ptb=0x040 page=3 entry=0x8012 -> one pt_we at N+1, addr 0x043 data 0x8012;
//   done at N+2.
//  MAP ptb=0x020 page=4 count=3 entry=0xC07E -> addr 0x24/0x25/0x26 data
//   0xC07E/0xC07F/0xC000; done, err=0.
//  CLEAR ptb=0x1F0 -> 32 writes of 0x0000, addr 0x1F0..0x1FF then 0x000..0x00F (wrap).
//  MAP page=30 count=3 -> no pt_we, done=1 err=1; op=11 likewise.
//  rst_n low during 4th CLEAR write -> next cycle pt_we=0, cmd_ready=1, no done pulse.
//  VERIFY_EN: RAM model corrupts 2nd MAP write -> 2 writes only, done=1 err=1.

Source files
------------

// File: rtl/page_table_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_writer_if
//  Description : Command and page-table-RAM bundle between the kernel/exec
//                unit (master) and the page table writer (slave). The RAM
//                write/read port is carried on the same bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface page_table_writer_if #(
  parameter int PAGE_W  = 5,
  parameter int PTB_W   = 12,
  parameter int PTA_W   = 9,
  parameter int ENTRY_W = 16
);
  // Command channel
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [PTB_W-1:0]   cmd_ptb;
  logic [PAGE_W-1:0]  cmd_page;
  logic [PAGE_W:0]    cmd_count;
  logic [ENTRY_W-1:0] cmd_entry;

  // Page table RAM port
  logic               pt_we;
  logic [PTA_W-1:0]   pt_addr;
  logic [ENTRY_W-1:0] pt_wdata;
  logic [ENTRY_W-1:0] pt_rdata;

  // Completion status
  logic               done;
  logic               err;

  // Writer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_ptb, cmd_page, cmd_count, cmd_entry, pt_rdata,
    output cmd_ready, pt_we, pt_addr, pt_wdata, done, err
  );

  // Kernel / RAM side
  modport master (
    output cmd_valid, cmd_op, cmd_ptb, cmd_page, cmd_count, cmd_entry, pt_rdata,
    input  cmd_ready, pt_we, pt_addr, pt_wdata, done, err
  );
endinterface : page_table_writer_if
`default_nettype wire

// File: rtl/page_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_writer
//  Description : Sequential writer for the per-process page table RAM. Installs
//                one entry (WRITE), maps a run of pages onto consecutive frames
//                (MAP) or zeroes a whole table (CLEAR), one entry per cycle at
//                pt_addr = ptb + page with 9-bit wrap.
//                Optional feature macro: PT_WRITER_VERIFY_EN - read back each
//                written entry in a VERIFY cycle and abort on mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module page_table_writer #(
  parameter int PAGES   = 32,
  parameter int PTA_W   = 9,
  parameter int ENTRY_W = 16,
  parameter int PTB_W   = 12
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  page_table_writer_if.slave bus
);

  localparam int PAGE_W  = $clog2(PAGES);
  localparam int CNT_W   = PAGE_W + 1;
  localparam int FRAME_W = 7;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_MAP   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [CNT_W:0]    PAGES_C  = PAGES[CNT_W:0];
  localparam logic [PAGE_W-1:0] LAST_IDX = PAGE_W'(PAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
`ifdef PT_WRITER_VERIFY_EN
    S_VERIFY = 2'd3,
`endif
    S_FIN    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [PTA_W-1:0]   ptb_q;       // table base, already reduced to RAM width
  logic [PAGE_W-1:0]  idx_q;       // page index of the entry currently on the bus
  logic [PAGE_W-1:0]  left_q;      // writes still to come after the current one
  logic               map_q;       // frame field advances on every write
  logic               cmd_ready_q;
  logic               pt_we_q;
  logic [PTA_W-1:0]   pt_addr_q;
  logic [ENTRY_W-1:0] pt_wdata_q;
  logic               done_q;
  logic               err_q;

  // --------------------------------------------------------------------------
  // Next-value helpers
  // --------------------------------------------------------------------------
  logic [PAGE_W-1:0]  start_idx_d;
  logic [PTA_W-1:0]   start_addr_d;
  logic [ENTRY_W-1:0] start_data_d;
  logic [PAGE_W-1:0]  start_left_d;
  logic [CNT_W:0]     map_end_d;
  logic               reject_d;
  logic               empty_map_d;
  logic [PAGE_W-1:0]  next_idx_d;
  logic [PTA_W-1:0]   next_addr_d;
  logic [ENTRY_W-1:0] next_wdata_d;

  // Decode an offered command and precompute the following entry of a run
  always_comb begin
    start_idx_d  = (bus.cmd_op == OP_CLEAR) ? '0 : bus.cmd_page;
    start_addr_d = bus.cmd_ptb[PTA_W-1:0] + PTA_W'(start_idx_d);
    start_data_d = (bus.cmd_op == OP_CLEAR) ? '0 : bus.cmd_entry;

    start_left_d = '0;
    if (bus.cmd_op == OP_MAP)   start_left_d = PAGE_W'(bus.cmd_count - 1'b1);
    if (bus.cmd_op == OP_CLEAR) start_left_d = LAST_IDX;

    // page + count computed one bit wider so a run ending exactly at the
    // last page is accepted and anything beyond it is caught.
    map_end_d   = {2'b00, bus.cmd_page} + {1'b0, bus.cmd_count};
    reject_d    = (bus.cmd_op == 2'b11) ||
                  ((bus.cmd_op == OP_MAP) && (map_end_d > PAGES_C));
    empty_map_d = (bus.cmd_op == OP_MAP) && (bus.cmd_count == '0);

    next_idx_d   = idx_q + 1'b1;
    next_addr_d  = ptb_q + PTA_W'(next_idx_d);
    next_wdata_d = pt_wdata_q;
    if (map_q) begin
      next_wdata_d[FRAME_W-1:0] = pt_wdata_q[FRAME_W-1:0] + 1'b1;
    end
  end

  // Command sequencer: accept, stream entries, optionally verify, report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptb_q       <= '0;
      idx_q       <= '0;
      left_q      <= '0;
      map_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      pt_we_q     <= 1'b0;
      pt_addr_q   <= '0;
      pt_wdata_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            ptb_q       <= bus.cmd_ptb[PTA_W-1:0];
            idx_q       <= start_idx_d;
            map_q       <= (bus.cmd_op == OP_MAP);
            if (reject_d) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (empty_map_d) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_WRITE;
              pt_we_q    <= 1'b1;
              pt_addr_q  <= start_addr_d;
              pt_wdata_q <= start_data_d;
              left_q     <= start_left_d;
            end
          end
        end

`ifdef PT_WRITER_VERIFY_EN
        // Hold the address with the write strobe dropped; the RAM returns the
        // entry just written during this cycle.
        S_WRITE: begin
          pt_we_q <= 1'b0;
          state_q <= S_VERIFY;
        end

        S_VERIFY: begin
          if (bus.pt_rdata != pt_wdata_q) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (left_q == '0) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_WRITE;
            pt_we_q    <= 1'b1;
            pt_addr_q  <= next_addr_d;
            pt_wdata_q <= next_wdata_d;
            idx_q      <= next_idx_d;
            left_q     <= left_q - 1'b1;
          end
        end
`else
        S_WRITE: begin
          if (left_q == '0) begin
            state_q <= S_FIN;
            pt_we_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pt_addr_q  <= next_addr_d;
            pt_wdata_q <= next_wdata_d;
            idx_q      <= next_idx_d;
            left_q     <= left_q - 1'b1;
          end
        end
`endif

        S_FIN: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          pt_we_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.pt_we     = pt_we_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wdata  = pt_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Table base bits above the RAM width never reach the address; read data is
  // only consumed when read-back verification is built in.
`ifdef PT_WRITER_VERIFY_EN
  logic unused_bits;
  assign unused_bits = ^bus.cmd_ptb[PTB_W-1:PTA_W];
`else
  logic unused_bits;
  assign unused_bits = ^{bus.cmd_ptb[PTB_W-1:PTA_W], bus.pt_rdata};
`endif

endmodule : page_table_writer
`default_nettype wire

// File: tb/tb_page_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_table_writer
//  Description : Directed self-checking bench for page_table_writer with a
//                behavioural page table RAM (1-cycle read latency, write-first,
//                optional single-address read corruption).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_page_table_writer;

`ifdef PT_WRITER_VERIFY_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:511];
  logic        corrupt_en   = 1'b0;
  logic [8:0]  corrupt_addr = '0;
  logic [8:0]  wlog_addr [$];
  logic [15:0] wlog_data [$];

  logic [15:0] map_exp [3] = '{16'hC07E, 16'hC07F, 16'hC000};

  page_table_writer_if ptw ();

  page_table_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ptw)
  );

  always #5 clk = ~clk;

  // RAM model and write log
  always @(posedge clk) begin
    if (ptw.pt_we) begin
      mem[ptw.pt_addr] <= ptw.pt_wdata;
      wlog_addr.push_back(ptw.pt_addr);
      wlog_data.push_back(ptw.pt_wdata);
    end
    ptw.pt_rdata <= (ptw.pt_we ? ptw.pt_wdata : mem[ptw.pt_addr]) ^
                    ((corrupt_en && (ptw.pt_addr == corrupt_addr)) ? 16'h0001 : 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a command, wait (bounded) for acceptance; returns in cycle N+1
  task automatic send(input logic [1:0] op, input logic [11:0] ptb, input logic [4:0] page,
                      input logic [5:0] count, input logic [15:0] entry);
    int w;
    w = 0;
    ptw.cmd_op    = op;
    ptw.cmd_ptb   = ptb;
    ptw.cmd_page  = page;
    ptw.cmd_count = count;
    ptw.cmd_entry = entry;
    ptw.cmd_valid = 1'b1;
    while (!ptw.cmd_ready && w < 50) begin
      tick();
      w++;
    end
    check("send_ready", ptw.cmd_ready, 1'b1);
    tick();
    ptw.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for done; lat = cycle index relative to the accept edge
  task automatic wait_done(input int start, output int lat, output logic err_seen);
    lat = start;
    while (!ptw.done && lat < 200) begin
      tick();
      lat++;
    end
    check("done_seen", ptw.done, 1'b1);
    err_seen = ptw.err;
  endtask

  initial begin
    int   base;
    int   lat;
    int   bad;
    logic e;
    logic seen;
    logic [8:0] ea;

    ptw.cmd_valid = 1'b0;
    ptw.cmd_op    = 2'b00;
    ptw.cmd_ptb   = '0;
    ptw.cmd_page  = '0;
    ptw.cmd_count = '0;
    ptw.cmd_entry = '0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ready", ptw.cmd_ready, 1'b1);
    check("rst_we",    ptw.pt_we,     1'b0);
    check("rst_addr",  ptw.pt_addr,   9'h000);
    check("rst_wdata", ptw.pt_wdata,  16'h0000);
    check("rst_done",  ptw.done,      1'b0);
    check("rst_err",   ptw.err,       1'b0);
    rst_n = 1'b1;
    tick();

    // WRITE one entry
    base = wlog_addr.size();
    send(2'b00, 12'h040, 5'd3, 6'd0, 16'h8012);
    check("wr_we",    ptw.pt_we,     1'b1);
    check("wr_addr",  ptw.pt_addr,   9'h043);
    check("wr_data",  ptw.pt_wdata,  16'h8012);
    check("wr_busy",  ptw.cmd_ready, 1'b0);
    check("wr_early", ptw.done,      1'b0);
    wait_done(1, lat, e);
    check("wr_lat",   lat, STEP + 1);
    check("wr_err",   e, 1'b0);
    check("wr_fin_we", ptw.pt_we, 1'b0);
    check("wr_count", wlog_addr.size() - base, 1);
    tick();
    check("wr_ready_back", ptw.cmd_ready, 1'b1);
    check("wr_done_pulse", ptw.done, 1'b0);

    // MAP run of three with frame wrap; a command offered while busy is ignored
    base = wlog_addr.size();
    send(2'b01, 12'h020, 5'd4, 6'd3, 16'hC07E);
    check("map_first_addr", ptw.pt_addr, 9'h024);
    ptw.cmd_op    = 2'b00;
    ptw.cmd_ptb   = 12'h100;
    ptw.cmd_page  = 5'd0;
    ptw.cmd_entry = 16'hDEAD;
    ptw.cmd_valid = 1'b1;
    tick();
    ptw.cmd_valid = 1'b0;
    wait_done(2, lat, e);
    check("map_lat",   lat, 3 * STEP + 1);
    check("map_err",   e, 1'b0);
    check("map_count", wlog_addr.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      check("map_addr", wlog_addr[base + k], 9'(9'h024 + k));
      check("map_data", wlog_data[base + k], map_exp[k]);
    end
    tick();

    // CLEAR with address wrap past 0x1FF
    base = wlog_addr.size();
    send(2'b10, 12'h1F0, 5'd7, 6'd5, 16'hFFFF);
    wait_done(1, lat, e);
    check("clr_lat",   lat, 32 * STEP + 1);
    check("clr_err",   e, 1'b0);
    check("clr_count", wlog_addr.size() - base, 32);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      ea = 9'(12'h1F0 + k);
      if (wlog_addr[base + k] !== ea || wlog_data[base + k] !== 16'h0000) bad++;
    end
    check("clr_entries_bad", bad, 0);
    check("clr_addr_last_hi", wlog_addr[base + 15], 9'h1FF);
    check("clr_addr_wrap",    wlog_addr[base + 16], 9'h000);
    tick();

    // MAP ending exactly at the last page is accepted
    base = wlog_addr.size();
    send(2'b01, 12'h000, 5'd30, 6'd2, 16'h0005);
    wait_done(1, lat, e);
    check("edge_err",   e, 1'b0);
    check("edge_count", wlog_addr.size() - base, 2);
    check("edge_addr1", wlog_addr[base + 1], 9'h01F);
    check("edge_data1", wlog_data[base + 1], 16'h0006);
    tick();

    // MAP overrunning the table is rejected
    base = wlog_addr.size();
    send(2'b01, 12'h000, 5'd30, 6'd3, 16'h0005);
    check("rej_map_we", ptw.pt_we, 1'b0);
    wait_done(1, lat, e);
    check("rej_map_lat",   lat, 1);
    check("rej_map_err",   e, 1'b1);
    check("rej_map_count", wlog_addr.size() - base, 0);
    tick();

    // Reserved opcode is rejected
    base = wlog_addr.size();
    send(2'b11, 12'h040, 5'd1, 6'd1, 16'h8001);
    wait_done(1, lat, e);
    check("rej_op_lat",   lat, 1);
    check("rej_op_err",   e, 1'b1);
    check("rej_op_count", wlog_addr.size() - base, 0);
    tick();

    // MAP of zero pages completes at once without error
    base = wlog_addr.size();
    send(2'b01, 12'h040, 5'd2, 6'd0, 16'h8001);
    wait_done(1, lat, e);
    check("zero_lat",   lat, 1);
    check("zero_err",   e, 1'b0);
    check("zero_count", wlog_addr.size() - base, 0);
    tick();

    // Reset during the 4th CLEAR write
    base = wlog_addr.size();
    send(2'b10, 12'h000, 5'd0, 6'd0, 16'h0000);
    repeat (3 * STEP) tick();
    check("rstmid_we4",   ptw.pt_we,   1'b1);
    check("rstmid_addr4", ptw.pt_addr, 9'h003);
    rst_n = 1'b0;
    tick();
    check("rstmid_we",    ptw.pt_we,     1'b0);
    check("rstmid_ready", ptw.cmd_ready, 1'b1);
    check("rstmid_done",  ptw.done,      1'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ptw.done) seen = 1'b1;
    end
    check("rstmid_no_done", seen, 1'b0);
    check("rstmid_count",   wlog_addr.size() - base, 4);

`ifdef PT_WRITER_VERIFY_EN
    // Read-back of the 2nd MAP entry is corrupted: abort after two writes
    corrupt_addr = 9'h081;
    corrupt_en   = 1'b1;
    base = wlog_addr.size();
    send(2'b01, 12'h080, 5'd0, 6'd3, 16'h8001);
    wait_done(1, lat, e);
    check("vfy_lat",   lat, 5);
    check("vfy_err",   e, 1'b1);
    check("vfy_count", wlog_addr.size() - base, 2);
    corrupt_en = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_page_table_writer
`default_nettype wire
